// File: rtl/demod_pkg.sv
// -----------------------------------------------------------------------------
// demod_pkg
// Shared definitions for the demodulator sweep controller.
//   - FSM state encoding (kept as plain localparam vectors so legacy blocks that
//     compare against raw codes keep working)
//   - Default datapath widths
// -----------------------------------------------------------------------------
package demod_pkg;

  localparam int DEF_STEP_W = 8;
  localparam int DEF_AMP_W  = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_ACCUM  = 3'd2;
  localparam logic [2:0] ST_OUTPUT = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;

endpackage

// File: rtl/sample_averager.sv
// -----------------------------------------------------------------------------
// sample_averager
// Accumulates 2^AVG_LOG2 amplitude samples and presents their truncated mean.
//
// Ports
//   clk, rst_n  clock / async active-low reset
//   clr         synchronous clear of accumulator and sample counter (wins over en)
//   en          sample strobe; amp is added when high
//   amp         amplitude sample
//   avg         mean of the current block including the sample on amp
//               (meaningful only while avg_done is high)
//   avg_done    high in the cycle the last sample of a block is strobed in
// -----------------------------------------------------------------------------
module sample_averager
  import demod_pkg::*;
#(
  parameter int AMP_W    = DEF_AMP_W,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [AMP_W-1:0] amp,
  output logic [AMP_W-1:0] avg,
  output logic             avg_done
);

  // 2^AVG_LOG2 samples of at most 2^AMP_W-1 fit in AMP_W+AVG_LOG2 bits.
  localparam int ACC_W = AMP_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;

  // The final sample is folded in combinationally so the mean is ready in the
  // same cycle as its strobe; the caller registers it one clock later.
  assign acc_sum  = acc + ACC_W'(amp);
  assign avg_done = en && (cnt == CNT_LAST);
  assign avg      = acc_sum[ACC_W-1:AVG_LOG2];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr || avg_done) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demod_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// demod_sweep_ctrl
// Frequency-sweep scheduler in the clk_adc domain. Steps the DDS module_step
// from step_start towards step_stop by step_inc; at each point it enables the
// ADC, discards SETTLE_N settling samples, averages 2^AVG_LOG2 amplitude
// samples and emits one (step, amplitude) result on a valid/ready stream.
//
// Ports
//   clk, rst_n                       clock / async active-low reset
//   start, abort                     sweep control (abort always wins)
//   step_start/step_stop/step_inc    sweep configuration, latched on start
//   en_data, amp                     sample strobe and amplitude
//   module_step                      DDS phase step (registered)
//   adc_go                           ADC conversion enable (registered)
//   res_valid/res_ready              result handshake
//   res_step, res_amp                result payload
//   busy                             high outside IDLE
//   done                             one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module demod_sweep_ctrl
  import demod_pkg::*;
#(
  parameter int STEP_W   = DEF_STEP_W,
  parameter int AMP_W    = DEF_AMP_W,
  parameter int SETTLE_N = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] step_start,
  input  logic [STEP_W-1:0] step_stop,
  input  logic [STEP_W-1:0] step_inc,
  input  logic              en_data,
  input  logic [AMP_W-1:0]  amp,
  output logic [STEP_W-1:0] module_step,
  output logic              adc_go,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [STEP_W-1:0] res_step,
  output logic [AMP_W-1:0]  res_amp,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] SETTLE_LAST = (SETTLE_N == 0) ? 8'd0 : 8'(SETTLE_N - 1);

  logic [2:0]        state;
  logic [STEP_W-1:0] stop_q;
  logic [STEP_W-1:0] inc_q;
  logic [7:0]        settle_cnt;
  logic              settle_done;
  logic [STEP_W:0]   nxt_sum;
  logic              nxt_end;
  logic              avg_en;
  logic              avg_clr;
  logic [AMP_W-1:0]  avg;
  logic              avg_done;

  // One extra bit catches wrap-around past the top of the step range.
  assign nxt_sum = {1'b0, module_step} + {1'b0, inc_q};
  assign nxt_end = (inc_q == '0) || nxt_sum[STEP_W] || (nxt_sum[STEP_W-1:0] > stop_q);

  // With SETTLE_N=0 the settle phase lasts exactly one cycle. The pulse that
  // completes the count is consumed here and never reaches the averager.
  assign settle_done = (SETTLE_N == 0) || (en_data && (settle_cnt == SETTLE_LAST));

  // The averager only sees samples while accumulating; any other state, or an
  // abort, keeps it cleared so every point starts from a fresh average.
  assign avg_en  = (state == ST_ACCUM) && en_data && !abort;
  assign avg_clr = (state != ST_ACCUM) || abort;

  assign busy = (state != ST_IDLE);

  sample_averager #(
    .AMP_W    (AMP_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (avg_clr),
    .en       (avg_en),
    .amp      (amp),
    .avg      (avg),
    .avg_done (avg_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stop_q      <= '0;
      inc_q       <= '0;
      settle_cnt  <= '0;
      module_step <= '0;
      adc_go      <= 1'b0;
      res_valid   <= 1'b0;
      res_step    <= '0;
      res_amp     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // module_step is deliberately left at its last value. A handshake in
        // this same cycle still delivers the result: only res_valid drops.
        state      <= ST_IDLE;
        adc_go     <= 1'b0;
        res_valid  <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              stop_q      <= step_stop;
              inc_q       <= step_inc;
              module_step <= step_start;
              settle_cnt  <= '0;
              adc_go      <= 1'b1;
              state       <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_done) begin
              settle_cnt <= '0;
              state      <= ST_ACCUM;
            end else if (en_data) begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
          ST_ACCUM: begin
            if (avg_done) begin
              res_amp   <= avg;
              res_step  <= module_step;
              res_valid <= 1'b1;
              adc_go    <= 1'b0;
              state     <= ST_OUTPUT;
            end
          end
          ST_OUTPUT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (nxt_end) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              module_step <= nxt_sum[STEP_W-1:0];
              adc_go      <= 1'b1;
              state       <= ST_SETTLE;
            end
          end
          default: begin
            adc_go    <= 1'b0;
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demod_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demod_sweep_ctrl
// Scoreboard bench for demod_sweep_ctrl (SETTLE_N=2, AVG_LOG2=1). Each sweep
// pushes its expected (step, amp) results; the monitor pops and compares on
// every res_valid & res_ready handshake. A sample source emits en_data every
// other cycle while adc_go is high, taking amplitudes from amp_q (or
// amp_default when the queue is empty).
// -----------------------------------------------------------------------------
module tb_demod_sweep_ctrl;

  localparam int STEP_W   = 8;
  localparam int AMP_W    = 10;
  localparam int SETTLE_N = 2;
  localparam int AVG_LOG2 = 1;

  typedef struct {
    logic [STEP_W-1:0] step;
    logic [AMP_W-1:0]  amp;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] step_start;
  logic [STEP_W-1:0] step_stop;
  logic [STEP_W-1:0] step_inc;
  logic              en_data;
  logic [AMP_W-1:0]  amp;
  logic [STEP_W-1:0] module_step;
  logic              adc_go;
  logic              res_valid;
  logic              res_ready;
  logic [STEP_W-1:0] res_step;
  logic [AMP_W-1:0]  res_amp;
  logic              busy;
  logic              done;

  res_t             exp_q[$];
  logic [AMP_W-1:0] amp_q[$];
  logic [AMP_W-1:0] amp_default;
  bit               force_en;
  bit               gen_phase;
  int               pulses_total;
  int               done_cnt;
  int               n_tests;
  int               n_fail;

  always #5 clk = ~clk;

  demod_sweep_ctrl #(
    .STEP_W   (STEP_W),
    .AMP_W    (AMP_W),
    .SETTLE_N (SETTLE_N),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .step_start  (step_start),
    .step_stop   (step_stop),
    .step_inc    (step_inc),
    .en_data     (en_data),
    .amp         (amp),
    .module_step (module_step),
    .adc_go      (adc_go),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_step    (res_step),
    .res_amp     (res_amp),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sample source: one strobe every other cycle while the ADC is enabled.
  // force_en emits junk strobes regardless of adc_go.
  always @(negedge clk) begin
    if (!gen_phase && (adc_go || force_en)) begin
      en_data = 1'b1;
      if (adc_go) begin
        pulses_total++;
        amp = (amp_q.size() > 0) ? amp_q.pop_front() : amp_default;
      end else begin
        amp = 10'd999;
      end
      gen_phase = 1'b1;
    end else begin
      en_data   = 1'b0;
      gen_phase = 1'b0;
    end
  end

  // Monitor: samples mid-low phase, well clear of the active edge.
  always @(negedge clk) begin
    res_t e;
    #2;
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("result_expected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("res_step", 32'(res_step), 32'(e.step));
          check("res_amp", 32'(res_amp), 32'(e.amp));
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 0);
      end
    end
  end

  task automatic push_exp(input logic [STEP_W-1:0] s, input logic [AMP_W-1:0] a);
    res_t e;
    e.step = s;
    e.amp  = a;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [STEP_W-1:0] s0, input logic [STEP_W-1:0] s1,
                          input logic [STEP_W-1:0] inc);
    @(negedge clk);
    step_start = s0;
    step_stop  = s1;
    step_inc   = inc;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #3;
    check("start_busy", 32'(busy), 1);
    check("start_step", 32'(module_step), 32'(s0));
    check("start_adc_go", 32'(adc_go), 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n    = 0;
    int prev = done_cnt;
    while (done_cnt == prev && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(tag, 32'(done_cnt - prev), 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(tag, 32'(res_valid), 1);
  endtask

  initial begin
    int p0;
    int d0;
    int n;
    bit stable;

    n_tests = 0; n_fail = 0; pulses_total = 0; done_cnt = 0;
    gen_phase = 1'b0; force_en = 1'b0; amp_default = 10'd100;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    step_start = '0; step_stop = '0; step_inc = '0;
    en_data = 1'b0; amp = '0;

    // Reset state
    #23;
    check("rst_module_step", 32'(module_step), 0);
    check("rst_adc_go", 32'(adc_go), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_step", 32'(res_step), 0);
    check("rst_res_amp", 32'(res_amp), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic sweep 10..12, constant amplitude; a start while busy is ignored
    amp_default = 10'd100;
    push_exp(8'd10, 10'd100);
    push_exp(8'd11, 10'd100);
    push_exp(8'd12, 10'd100);
    p0 = pulses_total;
    do_start(8'd10, 8'd12, 8'd1);
    repeat (3) @(negedge clk);
    step_start = 8'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    wait_done("t1_done", 300);
    check("t1_pulses", 32'(pulses_total - p0), 12);
    repeat (10) @(negedge clk);
    check("t1_single_done", 32'(done_cnt - d0), 1);
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // Truncation 5,6 -> 5, and inc=0 gives a single point
    amp_q = '{10'd0, 10'd0, 10'd5, 10'd6};
    push_exp(8'd7, 10'd5);
    do_start(8'd7, 8'd200, 8'd0);
    wait_done("t2_done", 200);
    check("t2_sb_empty", 32'(exp_q.size()), 0);
    check("t2_amp_q_used", 32'(amp_q.size()), 0);

    // Full-scale samples, start > stop gives one point
    amp_q = '{10'd0, 10'd0, 10'd1023, 10'd1023};
    push_exp(8'd20, 10'd1023);
    do_start(8'd20, 8'd10, 8'd1);
    wait_done("t2b_done", 200);
    check("t2b_sb_empty", 32'(exp_q.size()), 0);

    // Wrap: 250, 254, then 258 overflows the step range
    amp_default = 10'd100;
    push_exp(8'd250, 10'd100);
    push_exp(8'd254, 10'd100);
    do_start(8'd250, 8'd255, 8'd4);
    wait_done("t3_done", 300);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // Backpressure: 50 stalled cycles with junk strobes
    amp_default = 10'd77;
    res_ready = 1'b0;
    push_exp(8'd30, 10'd77);
    push_exp(8'd31, 10'd77);
    do_start(8'd30, 8'd31, 8'd1);
    wait_valid("t4_valid", 200);
    force_en = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (!res_valid || res_step != 8'd30 || res_amp != 10'd77 || adc_go || module_step != 8'd30)
        stable = 1'b0;
    end
    check("t4_stable", 32'(stable), 1);
    check("t4_adc_go_low", 32'(adc_go), 0);
    check("t4_step_held", 32'(module_step), 30);
    @(negedge clk);
    force_en  = 1'b0;
    res_ready = 1'b1;
    wait_done("t4_done", 300);
    check("t4_sb_empty", 32'(exp_q.size()), 0);

    // Abort after the first accumulated sample
    amp_default = 10'd40;
    p0 = pulses_total;
    d0 = done_cnt;
    do_start(8'd3, 8'd5, 8'd1);
    n = 0;
    while (pulses_total < p0 + 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_reach_accum", 32'(pulses_total - p0), 3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #3;
    check("t5_busy", 32'(busy), 0);
    check("t5_res_valid", 32'(res_valid), 0);
    check("t5_adc_go", 32'(adc_go), 0);
    check("t5_step_kept", 32'(module_step), 3);
    repeat (3) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 0);
    amp_q = '{10'd0, 10'd0, 10'd8, 10'd10, 10'd0, 10'd0, 10'd20, 10'd21};
    push_exp(8'd3, 10'd9);
    push_exp(8'd4, 10'd20);
    do_start(8'd3, 8'd4, 8'd1);
    wait_done("t5_done", 300);
    check("t5_sb_empty", 32'(exp_q.size()), 0);

    // start and abort together in IDLE
    @(negedge clk);
    step_start = 8'd90;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #3;
    check("t6_busy", 32'(busy), 0);
    check("t6_adc_go", 32'(adc_go), 0);
    check("t6_step", 32'(module_step), 4);

    // Asynchronous reset while holding a result
    res_ready = 1'b0;
    push_exp(8'd60, 10'd40);
    do_start(8'd60, 8'd60, 8'd1);
    wait_valid("t7_valid", 200);
    exp_q.delete();
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_module_step", 32'(module_step), 0);
    check("t7_adc_go", 32'(adc_go), 0);
    check("t7_res_valid", 32'(res_valid), 0);
    check("t7_res_step", 32'(res_step), 0);
    check("t7_res_amp", 32'(res_amp), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("t7_idle_after", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
